// File: rtl/aes_128_dec_top.sv
// ---------------------------------------------------------------------------
// aes_128_dec_top
//
// Iterative AES-128 inverse cipher. One ciphertext block is accepted, round
// keys are pulled from an external key schedule in reverse order (K10..K0),
// and the plaintext is presented after a fixed latency of 1 + ROUNDS*L
// cycles, where L = SBOX_LAT + 2 is the length of one round.
//
// Ports
//   clk        in   1    clock, rising edge
//   kill_n     in   1    asynchronous active-low reset
//   in_data    in   128  ciphertext, sampled in the accept cycle
//   in_en      in   1    start strobe, accepted only in IDLE or DONE
//   key_round  in   128  current round key, sampled whenever key_ready=1
//   key_ready  out  1    key_round consumed this cycle, source advances
//   busy       out  1    block in flight (accept cycle and DONE excluded)
//   out_data   out  128  plaintext, held until the next block completes
//   out_en     out  1    one-cycle pulse, out_data is new and valid
//
// Handshake: there is no backpressure in either direction. in_en is a
// strobe that is either accepted (key_ready=1 in the same cycle) or silently
// dropped. key_ready is a consume pulse: the key source must present the
// next round key in the cycle after each pulse. out_en is a valid-only pulse.
//
// Round structure (phase_cnt 0..L-1):
//   phase 0          InvShiftRows, S-box addresses registered
//   phase 1..LAT     wait for S-box read data
//   phase L-1        AddRoundKey, then InvMixColumns unless last round
// Byte 0 (row 0, column 0) sits at bits [127:120]; byte index = 4*col + row.
// ---------------------------------------------------------------------------
module aes_128_dec_top #(
  parameter int ROUNDS   = 10,
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         kill_n,
  input  logic [127:0] in_data,
  input  logic         in_en,
  input  logic [127:0] key_round,
  output logic         key_ready,
  output logic         busy,
  output logic [127:0] out_data,
  output logic         out_en
);

  localparam int L  = SBOX_LAT + 2;
  localparam int PW = $clog2(L);
  localparam int RW = $clog2(ROUNDS + 1);

  // Inverse S-box, byte b at bits [2047-8*b -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Datapath functions
  // -------------------------------------------------------------------------
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r is rotated right by r positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    end
    return o;
  endfunction

  // Multiples by 09/0b/0d/0e built from one shared x2/x4/x8 chain per byte.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [127:0]   data_q, data_d;
  logic [RW-1:0]  round_cnt_q, round_cnt_d;
  logic [PW-1:0]  phase_cnt_q, phase_cnt_d;
  logic [127:0]   out_data_q, out_data_d;
  logic [127:0]   sbox_q [SBOX_LAT];
  logic [127:0]   sbox_d [SBOX_LAT];
  // Low for the first edge after kill_n release so that an in_en already
  // high while reset is lifted is not taken as a start.
  logic           arm_q;

  logic           accept;
  logic           last_phase;
  logic [127:0]   ark;

  // S-box ROM: addresses captured in phase 0, data walks down the pipe and is
  // consumed from the last stage in the final phase of the round.
  always_comb begin
    sbox_d[0] = sbox_q[0];
    if (state_q == ST_ROUND && phase_cnt_q == '0) begin
      sbox_d[0] = inv_sub_bytes(inv_shift_rows(data_q));
    end
    for (int i = 1; i < SBOX_LAT; i++) begin
      sbox_d[i] = sbox_q[i-1];
    end
  end

  // Control FSM next-state and outputs.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    round_cnt_d = round_cnt_q;
    phase_cnt_d = phase_cnt_q;
    out_data_d  = out_data_q;
    key_ready   = 1'b0;
    accept      = arm_q && in_en && (state_q == ST_IDLE || state_q == ST_DONE);
    last_phase  = (state_q == ST_ROUND) && (phase_cnt_q == PW'(L - 1));
    ark         = sbox_q[SBOX_LAT-1] ^ key_round;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          // Initial AddRoundKey with K10 happens in the accept cycle.
          state_d     = ST_ROUND;
          data_d      = in_data ^ key_round;
          round_cnt_d = RW'(ROUNDS - 1);
          phase_cnt_d = '0;
          key_ready   = 1'b1;
        end
      end
      ST_ROUND: begin
        if (last_phase) begin
          key_ready   = 1'b1;
          phase_cnt_d = '0;
          if (round_cnt_q == '0) begin
            out_data_d = ark;
            state_d    = ST_DONE;
          end else begin
            data_d      = inv_mix_columns(ark);
            round_cnt_d = round_cnt_q - RW'(1);
          end
        end else begin
          phase_cnt_d = phase_cnt_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      round_cnt_q <= '0;
      phase_cnt_q <= '0;
      out_data_q  <= '0;
      arm_q       <= 1'b0;
      for (int i = 0; i < SBOX_LAT; i++) begin
        sbox_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      round_cnt_q <= round_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      out_data_q  <= out_data_d;
      arm_q       <= 1'b1;
      for (int i = 0; i < SBOX_LAT; i++) begin
        sbox_q[i] <= sbox_d[i];
      end
    end
  end

  assign busy     = (state_q == ST_ROUND);
  assign out_en   = (state_q == ST_DONE);
  assign out_data = out_data_q;

endmodule

// File: tb/tb_aes_128_dec_top.sv
// ---------------------------------------------------------------------------
// tb_aes_128_dec_top
//
// Directed and randomized bench for aes_128_dec_top. Expected plaintexts come
// from an algorithmic InvCipher model whose S-boxes are derived from GF(2^8)
// inversion plus the affine map, and whose round keys come from a standard
// key expansion. A negedge monitor logs key_ready, out_en and busy cycles;
// each block's log is compared against the fixed timing (key pulses every 3
// cycles, result at cycle 31).
// ---------------------------------------------------------------------------
module tb_aes_128_dec_top;

  logic         clk;
  logic         kill_n;
  logic [127:0] in_data;
  logic         in_en;
  logic [127:0] key_round;
  logic         key_ready;
  logic         busy;
  logic [127:0] out_data;
  logic         out_en;

  aes_128_dec_top dut (
    .clk       (clk),
    .kill_n    (kill_n),
    .in_data   (in_data),
    .in_en     (in_en),
    .key_round (key_round),
    .key_ready (key_ready),
    .busy      (busy),
    .out_data  (out_data),
    .out_en    (out_en)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor / scoreboard state ----------------
  logic [127:0] exp_q[$];
  logic [127:0] key_q[$];
  int           kr_log[$];
  int           out_cyc_log[$];
  logic [127:0] out_val_log[$];
  int           busy_log[$];
  logic         kr_flag;
  int           checks   = 0;
  int           failures = 0;

  always @(negedge clk) begin
    kr_flag <= key_ready;
    if (key_ready === 1'b1) kr_log.push_back(cyc);
    if (out_en === 1'b1) begin
      out_cyc_log.push_back(cyc);
      out_val_log.push_back(out_data);
    end
    if (busy === 1'b1) busy_log.push_back(cyc);
  end

  // ---------------- reference model ----------------
  logic [7:0] fsb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sboxes();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      fsb[x] = s;
      isb[s] = x[7:0];
    end
  endtask

  // Round key r occupies ks[128*r +: 128].
  function automatic logic [1407:0] key_expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1407:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {fsb[tmp[31:24]], fsb[tmp[23:16]], fsb[tmp[15:8]], fsb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    ks = '0;
    for (int r = 0; r < 11; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [1407:0] ks);
    logic [7:0]   s    [16];
    logic [7:0]   t    [16];
    logic [7:0]   coef [4];
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ ks[1280 + 127 - 8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = isb[s[4*((c - row + 4) % 4) + row]] ^ ks[128*r + 127 - 8*(4*c+row) -: 8];
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) begin
          if (r != 0) begin
            s[4*c+k] = 8'h00;
            for (int j = 0; j < 4; j++) s[4*c+k] = s[4*c+k] ^ gmul(t[4*c+j], coef[(j - k + 4) % 4]);
          end else begin
            s[4*c+k] = t[4*c+k];
          end
        end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_logs();
    kr_log.delete();
    out_cyc_log.delete();
    out_val_log.delete();
    busy_log.delete();
  endtask

  // nblk blocks issued back-to-back starting at cycle start.
  task automatic check_block(input string tag, input int start, input int nblk);
    chk({tag, "_key_ready_count"}, kr_log.size(), 11 * nblk);
    for (int i = 0; i < kr_log.size() && i < 11 * nblk; i++)
      chk({tag, "_key_ready_cycle"}, kr_log[i] - start, 31 * (i / 11) + 3 * (i % 11));
    chk({tag, "_out_en_count"}, out_cyc_log.size(), nblk);
    for (int j = 0; j < out_cyc_log.size() && j < nblk; j++) begin
      chk({tag, "_out_en_cycle"}, out_cyc_log[j] - start, 31 * (j + 1));
      if (exp_q.size() > 0) chk({tag, "_out_data"}, out_val_log[j], exp_q.pop_front());
    end
    chk({tag, "_busy_cycles"}, busy_log.size(), 30 * nblk);
    exp_q.delete();
    clear_logs();
  endtask

  // ---------------- driver tasks ----------------
  // Advance n clocks; the key source pops a key after each consuming edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (kr_flag === 1'b1 && key_q.size() > 0) void'(key_q.pop_front());
      key_round = (key_q.size() > 0) ? key_q[0] : '0;
    end
  endtask

  task automatic issue(input logic [127:0] ct, input logic [127:0] key);
    logic [1407:0] ks;
    ks = key_expand(key);
    for (int r = 10; r >= 0; r--) key_q.push_back(ks[128*r +: 128]);
    key_round = key_q[0];
    in_data   = ct;
    in_en     = 1'b1;
    exp_q.push_back(model_dec(ct, ks));
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  // ---------------- directed sequence ----------------
  initial begin
    int start;
    kill_n    = 1'b0;
    in_en     = 1'b0;
    in_data   = '0;
    key_round = '0;
    build_sboxes();

    // T1 reset
    step(5);
    chk("t1_key_ready", key_ready, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_out_en", out_en, 1'b0);
    chk("t1_out_data", out_data, 128'h0);
    kill_n = 1'b1;
    step(2);
    clear_logs();

    // T2 FIPS-197 C.1
    start = cyc;
    issue(C1_CT, C1_KEY);
    step(1); in_en = 1'b0;
    step(32);
    chk("t2_kat", out_val_log.size() > 0 ? out_val_log[0] : 128'hx, C1_PT);
    check_block("t2", start, 1);
    step(2);
    chk("t2_hold_data", out_data, C1_PT);
    chk("t2_hold_out_en", out_en, 1'b0);

    // T3 FIPS-197 App.B
    start = cyc;
    issue(B_CT, B_KEY);
    step(1); in_en = 1'b0;
    step(32);
    chk("t3_kat", out_val_log.size() > 0 ? out_val_log[0] : 128'hx, B_PT);
    check_block("t3", start, 1);

    // T4 in_en while busy is ignored
    start = cyc;
    issue(C1_CT, C1_KEY);
    step(1);  in_en = 1'b0;
    step(4);  in_en = 1'b1; in_data = rand128();
    step(1);  in_en = 1'b0;
    step(11); in_en = 1'b1; in_data = rand128();
    step(1);  in_en = 1'b0;
    step(15);
    check_block("t4", start, 1);

    // T5 back-to-back, second block accepted in the DONE cycle
    start = cyc;
    issue(C1_CT, C1_KEY);
    step(1);  in_en = 1'b0;
    step(30);
    issue(B_CT, B_KEY);
    step(1);  in_en = 1'b0;
    step(32);
    chk("t5_kat_second", out_val_log.size() > 1 ? out_val_log[1] : 128'hx, B_PT);
    check_block("t5", start, 2);

    // T6 kill mid-block, release with in_en high, rerun
    start = cyc;
    issue(C1_CT, C1_KEY);
    step(1);  in_en = 1'b0;
    step(14);
    kill_n = 1'b0;
    #1;
    chk("t6_kill_key_ready", key_ready, 1'b0);
    chk("t6_kill_busy", busy, 1'b0);
    chk("t6_kill_out_en", out_en, 1'b0);
    chk("t6_kill_out_data", out_data, 128'h0);
    key_q.delete();
    exp_q.delete();
    key_round = '0;
    step(2);
    in_en   = 1'b1;
    in_data = rand128();
    kill_n  = 1'b1;
    step(1);
    in_en = 1'b0;
    chk("t6_release_no_accept", busy, 1'b0);
    step(2);
    chk("t6_release_idle", busy, 1'b0);
    clear_logs();
    start = cyc;
    issue(C1_CT, C1_KEY);
    step(1); in_en = 1'b0;
    step(32);
    check_block("t6_rerun", start, 1);

    // Randomized blocks against the model
    for (int n = 0; n < 5; n++) begin
      start = cyc;
      issue(rand128(), rand128());
      step(1); in_en = 1'b0;
      step(32);
      check_block("rand", start, 1);
      step($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
